alu_op_sequencer: RTL and testbench

- Initiator side of the 3-bit-select ALU interface. Accepts one command at a time over a valid/ready port and drives the ALU's a/b/sel inputs from registers.
- Samples the ALU's f/ovf/zero outputs, chains multiple ALU passes for compound ops (SUB, multi-bit SLL), and returns one response over a valid/ready port.
- Sits between the control/decode logic and the ALU in the multi-cycle datapath.

---
 rtl/alu_op_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Initiator-side sequencer for the 3-bit-select ALU: accepts one command, runs one or more
// registered ALU passes (chaining SUB and multi-bit SLL), and returns a single response.
module alu_op_sequencer #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         cmd_op,
    input  logic [DATA_W-1:0]  cmd_a,
    input  logic [DATA_W-1:0]  cmd_b,
    input  logic [SHAMT_W-1:0] cmd_shamt,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_result,
    output logic               rsp_ovf,
    output logic               rsp_taken,
    output logic               rsp_err,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [2:0]         alu_sel,
    input  logic [DATA_W-1:0]  alu_f,
    input  logic               alu_ovf,
    input  logic               alu_zero,
    output logic [2:0]         dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid-side
    // payloads are held stable until that edge.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXEC    = 3'd1,
        SHIFT   = 3'd2,
        SUB_NOT = 3'd3,
        SUB_ADD = 3'd4,
        SUB_INC = 3'd5,
        RESP    = 3'd6
    } state_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_NOT = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SLT = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_BEQ = 4'd6;
    localparam logic [3:0] OP_BNE = 4'd7;
    localparam logic [3:0] OP_SUB = 4'd8;

    localparam logic [2:0] SEL_ADD = 3'b000;
    localparam logic [2:0] SEL_NOT = 3'b001;
    localparam logic [2:0] SEL_SLL = 3'b101;

    state_t              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [DATA_W-1:0]   a_lat_q, a_lat_d;
    logic [DATA_W-1:0]   b_lat_q, b_lat_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [2:0]          alu_sel_q, alu_sel_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                ovf_q, ovf_d;
    logic                taken_q, taken_d;
    logic                err_q, err_d;
    logic                is_branch;

    assign is_branch = (op_q == OP_BEQ) || (op_q == OP_BNE);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_lat_d   = a_lat_q;
        b_lat_d   = b_lat_q;
        cnt_d     = cnt_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        taken_d   = taken_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    a_lat_d = cmd_a;
                    b_lat_d = cmd_b;
                    case (cmd_op)
                        OP_ADD, OP_NOT, OP_AND, OP_OR, OP_SLT, OP_BEQ, OP_BNE: begin
                            alu_a_d   = cmd_a;
                            alu_b_d   = cmd_b;
                            alu_sel_d = cmd_op[2:0];
                            state_d   = EXEC;
                        end
                        OP_SLL: begin
                            if (cmd_shamt != '0) begin
                                alu_a_d   = cmd_a;
                                alu_sel_d = SEL_SLL;
                                cnt_d     = cmd_shamt;
                                state_d   = SHIFT;
                            end else begin
                                result_d = cmd_a;
                                ovf_d    = 1'b0;
                                taken_d  = 1'b0;
                                err_d    = 1'b0;
                                state_d  = RESP;
                            end
                        end
                        OP_SUB: begin
                            alu_b_d   = cmd_b;
                            alu_sel_d = SEL_NOT;
                            state_d   = SUB_NOT;
                        end
                        default: begin
                            result_d = '0;
                            ovf_d    = 1'b0;
                            taken_d  = 1'b0;
                            err_d    = 1'b1;
                            state_d  = RESP;
                        end
                    endcase
                end
            end
            EXEC: begin
                // Branch selects leave f undefined, so only the zero flag is reported.
                result_d = is_branch ? '0 : alu_f;
                ovf_d    = (op_q == OP_ADD) && alu_ovf;
                taken_d  = is_branch && alu_zero;
                err_d    = 1'b0;
                state_d  = RESP;
            end
            SHIFT: begin
                if (cnt_q == SHAMT_W'(1)) begin
                    result_d = alu_f;
                    ovf_d    = 1'b0;
                    taken_d  = 1'b0;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end else begin
                    alu_a_d = alu_f;
                    cnt_d   = cnt_q - SHAMT_W'(1);
                end
            end
            SUB_NOT: begin
                alu_a_d   = a_lat_q;
                alu_b_d   = alu_f;
                alu_sel_d = SEL_ADD;
                state_d   = SUB_ADD;
            end
            SUB_ADD: begin
                alu_a_d   = alu_f;
                alu_b_d   = DATA_W'(1);
                alu_sel_d = SEL_ADD;
                state_d   = SUB_INC;
            end
            SUB_INC: begin
                // A + ~B + 1 hides the true overflow, so derive it from the operand signs.
                result_d = alu_f;
                ovf_d    = (a_lat_q[DATA_W-1] != b_lat_q[DATA_W-1]) &&
                           (alu_f[DATA_W-1] != a_lat_q[DATA_W-1]);
                taken_d  = 1'b0;
                err_d    = 1'b0;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            a_lat_q   <= '0;
            b_lat_q   <= '0;
            cnt_q     <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            taken_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_lat_q   <= a_lat_d;
            b_lat_q   <= b_lat_d;
            cnt_q     <= cnt_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            taken_q   <= taken_d;
            err_q     <= err_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_result = result_q;
    assign rsp_ovf    = ovf_q;
    assign rsp_taken  = taken_q;
    assign rsp_err    = err_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU closes the loop, and an operation-level
// reference model predicts result, flags and latency for directed and random commands.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic [4:0]  cmd_shamt = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_ovf, rsp_taken, rsp_err;
    logic [31:0] alu_a, alu_b, alu_f;
    logic [2:0]  alu_sel, dbg_state;
    logic        alu_ovf, alu_zero;

    int n_vec  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        taken;
        logic        err;
        int          lat;
    } exp_t;

    alu_op_sequencer #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shamt(cmd_shamt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_ovf(rsp_ovf), .rsp_taken(rsp_taken), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_f(alu_f), .alu_ovf(alu_ovf), .alu_zero(alu_zero),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // behavioural combinational ALU
    always_comb begin
        alu_f    = 32'hDEAD_BEEF;
        alu_ovf  = 1'b0;
        alu_zero = 1'b0;
        case (alu_sel)
            3'b000: begin
                alu_f   = alu_a + alu_b;
                alu_ovf = (alu_a[31] == alu_b[31]) && (alu_f[31] != alu_a[31]);
            end
            3'b001: alu_f = ~alu_b;
            3'b010: alu_f = alu_a & alu_b;
            3'b011: alu_f = alu_a | alu_b;
            3'b100: alu_f = {31'b0, $signed(alu_a) < $signed(alu_b)};
            3'b101: alu_f = {alu_a[30:0], 1'b0};
            3'b110: alu_zero = (alu_a == alu_b);
            default: alu_zero = (alu_a != alu_b);
        endcase
    end

    function automatic exp_t ref_model(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic [4:0] sh);
        exp_t   e;
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.res = '0; e.ovf = 1'b0; e.taken = 1'b0; e.err = 1'b0; e.lat = 2;
        case (op)
            4'd0: begin
                r = sa + sb; e.res = a + b;
                e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            4'd1: e.res = ~b;
            4'd2: e.res = a & b;
            4'd3: e.res = a | b;
            4'd4: e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'd5: begin
                e.res = a << sh;
                e.lat = (sh == 0) ? 1 : int'(sh) + 1;
            end
            4'd6: e.taken = (a == b);
            4'd7: e.taken = (a != b);
            4'd8: begin
                r = sa - sb; e.res = a - b; e.lat = 4;
                e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            default: begin e.err = 1'b1; e.lat = 1; end
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // driver: issue one command, measure latency, check the response, optionally
    // stall the consumer for `hold` cycles while poking cmd_valid, then handshake
    task automatic do_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input int hold);
        exp_t        e;
        int          lat;
        logic [2:0]  sel_hist[$];
        logic [31:0] exp_res;
        e = ref_model(op, a, b, sh);
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_shamt = sh;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        cmd_valid = 1'b0;
        sel_hist.push_back(alu_sel);
        while (rsp_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            sel_hist.push_back(alu_sel);
        end
        check($sformatf("latency op%0d", op), lat, e.lat);
        if (rsp_valid !== 1'b1) begin
            check("rsp_valid_timeout", rsp_valid, 1);
        end
        exp_q.push_back(e.res);
        exp_res = exp_q.pop_front();
        check($sformatf("result op%0d", op), rsp_result, exp_res);
        check($sformatf("ovf op%0d", op), rsp_ovf, e.ovf);
        check($sformatf("taken op%0d", op), rsp_taken, e.taken);
        check($sformatf("err op%0d", op), rsp_err, e.err);
        if (op == 4'd8 && sel_hist.size() >= 3) begin
            check("sub_sel0", sel_hist[0], 3'b001);
            check("sub_sel1", sel_hist[1], 3'b000);
            check("sub_sel2", sel_hist[2], 3'b000);
        end
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = $urandom; cmd_b = $urandom;
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_cmd_ready", cmd_ready, 0);
            check("hold_result", rsp_result, exp_res);
            check("hold_ovf", rsp_ovf, e.ovf);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("after_hs_valid", rsp_valid, 0);
        check("after_hs_ready", cmd_ready, 1);
    endtask

    initial begin
        // reset values
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_alu_sel", alu_sel, 0);
        check("rst_alu_a", alu_a, 0);
        rst = 1'b0;

        // reset asserted while sequencing a SUB (in SUB_ADD)
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 4'd8; cmd_a = 32'd5; cmd_b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_rsp", rsp_valid, 0);
        end
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_alu_sel", alu_sel, 0);
        check("abort_result", rsp_result, 0);
        check("abort_ovf", rsp_ovf, 0);
        check("abort_taken", rsp_taken, 0);
        check("abort_err", rsp_err, 0);

        // directed steps
        do_cmd(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 0);
        do_cmd(4'd0, 32'd5, 32'd7, 5'd0, 0);
        do_cmd(4'd8, 32'd5, 32'd7, 5'd0, 0);
        do_cmd(4'd8, 32'h8000_0000, 32'd1, 5'd0, 0);
        do_cmd(4'd5, 32'd3, 32'd0, 5'd0, 0);
        do_cmd(4'd5, 32'd3, 32'd0, 5'd1, 0);
        do_cmd(4'd5, 32'd3, 32'd0, 5'd31, 0);
        do_cmd(4'd6, 32'd9, 32'd9, 5'd0, 0);
        do_cmd(4'd7, 32'd9, 32'd9, 5'd0, 0);
        do_cmd(4'd4, 32'd2, 32'd3, 5'd0, 0);
        do_cmd(4'd12, 32'd1, 32'd2, 5'd0, 0);
        do_cmd(4'd3, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0, 5);
        do_cmd(4'd1, 32'd0, 32'h1234_5678, 5'd0, 0);

        // randomized commands
        for (int n = 0; n < 60; n++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            do_cmd(op, a, b, 5'($urandom_range(0, 31)), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
